dct_fetch_buffer: RTL
=====================

Name: dct_fetch_buffer

Overview:
- Double-buffered 8-sample source that serves the DCT engine's fetch port (fetch_addr in, fetch_data out).
- The upstream pixel path pushes bytes in order over a valid/ready handshake.
- A completed bank of 8 is exposed to the DCT. The DCT returns it with a release pulse, which frees the bank for refill.
- Optional JPEG level shift (unsigned pixel to signed sample) happens here, so the DCT sees two's-complement data.

Parameters:
- DATA_WIDTH, 8, sample width in bits.
- ADDR_WIDTH, 3, fetch address width; bank depth is 2**ADDR_WIDTH.
- LEVEL_SHIFT, 1, when 1 fetch_data = stored ^ (1 << (DATA_WIDTH-1)), i.e. pixel - 128; when 0 raw.

Ports:
- clock  input  1  single system clock; all logic on posedge, including the fetch side.
- nreset  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  upstream sample.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  buffer can accept a sample this cycle.
- fetch_addr  input  ADDR_WIDTH  DCT read index into the current read bank.
- fetch_data  output  DATA_WIDTH  registered read data, valid one cycle after fetch_addr.
- block_valid  output  1  read bank holds a complete block.
- block_release  input  1  single-cycle pulse: DCT done with current read bank.
- release_err  output  1  sticky; set by block_release while block_valid=0.

Behaviour:
- Clock and reset: one clock, "clock"; reset "nreset", asynchronous, active-low.
- Reset state:
  - wbank=0, rbank=0, wcount=0, bank_full=2'b00.
  - fetch_data=0, release_err=0.
  - Result: block_valid=0 and in_ready=1 from the first cycle after reset.
  - Sample storage is not reset.
- in_ready = !bank_full[wbank], combinational.
- Write path, on in_valid && in_ready:
  - mem[wbank][wcount] <= in_data; wcount <= wcount+1.
  - If the accepted sample is the last one (wcount==2**ADDR_WIDTH-1): bank_full[wbank] <= 1, wbank toggles, wcount wraps to 0.
  - A sample offered while in_ready=0 is not consumed; upstream holds it.
- block_valid = bank_full[rbank], combinational.
- Read path:
  - Every cycle, fetch_data <= shift(mem[rbank][fetch_addr]), regardless of block_valid. Latency is exactly 1 cycle.
  - The value is meaningless when block_valid=0 but must not be X after storage is written.
  - The read uses rbank as of the fetch_addr cycle.
- Release:
  - block_release && block_valid: bank_full[rbank] <= 0, rbank toggles.
  - block_release && !block_valid: no state change, release_err <= 1 (cleared only by reset).
- Simultaneous events:
  - Completing a write into bank A while releasing bank B (A≠B) applies both.
  - Write completion and release can never target the same bank: writes need !full, release needs full.
- Writes landing in the read bank: only possible before the bank is full. block_valid asserts the cycle after the 8th accept, and the first fetch of that bank returns the new data.
- Both banks full: in_ready=0 until a release. in_ready rises the cycle after the release (wbank==old rbank).
- Throughput: sustained 1 sample/cycle in, as long as the DCT releases one bank per 8+ cycles.
- Reset mid-fill or mid-read discards partial banks and pending blocks; there is no output glitch beyond the async clear.
- Level-shift arithmetic: MSB inversion only, no adder. Example: 8'h00→8'h80 (-128), 8'hFF→8'h7F (+127), 8'h80→8'h00.

Decomposition:
- Shared package (jfpjc_pkg):
  - DCT_N=8, SAMPLE_WIDTH=8, FETCH_ADDR_WIDTH=3.
  - The level-shift constant, shared with loeffler-style DCT consumers.
- One natural sub-module: dct_fetch_bank_mem, a 2x(2**ADDR_WIDTH) x DATA_WIDTH simple dual-port with registered read. It is mappable to ice40_ebr or to LUT RAM; the top contains pointers, flags and handshake.

Test Plan:
1. Reset, then push 0x00..0x07 with in_valid held high → block_valid rises the cycle after the 8th accept. Fetch addr 0..7 gives fetch_data 0x80..0x87 one cycle later (LEVEL_SHIFT=1).
2. Push 16 samples 0x10..0x1F with no release → in_ready drops after the 16th accept; a 17th sample is held. Release → in_ready=1 next cycle. Fetch addr 0 gives 0x98 (second bank, 0x18^0x80).
3. block_release with block_valid=0 straight after reset → release_err=1 and stays 1; bank pointers unchanged; the subsequent fill of 8 behaves as in test 1.
4. Same cycle as the 8th accept into bank 1, pulse release of bank 0 → bank_full=2'b10, rbank=1, block_valid=1 continuously, in_ready=1.
5. Assert nreset low asynchronously mid-fill (wcount=5) → block_valid=0, in_ready=1, fetch_data=0 immediately. The next 8 pushes form block 0 cleanly.
6. LEVEL_SHIFT=0, push 0xFF,0x00,0x80,… → fetch addrs 0,1,2 return 0xFF,0x00,0x80. Randomized valid/release throttling against a scoreboard shows no loss, duplication or reordering.

Source files
------------

// File: rtl/jfpjc_pkg.sv
// Shared constants for the JPEG DCT front end: block geometry, sample width
// and the level-shift mask used by the fetch buffer and its DCT consumers.
package jfpjc_pkg;

   localparam int DCT_N            = 8;
   localparam int SAMPLE_WIDTH     = 8;
   localparam int FETCH_ADDR_WIDTH = 3;

   // Unsigned pixel to signed sample: inverting the MSB is the same as
   // subtracting 2**(SAMPLE_WIDTH-1), so no adder is needed.
   localparam logic [SAMPLE_WIDTH-1:0] LEVEL_SHIFT_MASK = 8'h80;

   // Identifies one of the two ping-pong banks.
   typedef enum logic {
      BANK_0 = 1'b0,
      BANK_1 = 1'b1
   } bank_t;

   // The partner of a bank in the ping-pong pair.
   function automatic bank_t other_bank(input bank_t b);
      return (b == BANK_0) ? BANK_1 : BANK_0;
   endfunction

endpackage

// File: rtl/dct_fetch_bank_mem.sv
// Two banks of 2**ADDR_WIDTH samples with one write port and one registered
// read port. Plain array plus output register, so it maps onto block RAM or
// distributed RAM.
module dct_fetch_bank_mem
   import jfpjc_pkg::*;
#(
   parameter int DATA_WIDTH = SAMPLE_WIDTH,
   parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  wr_en_i,
   input  bank_t                 wr_bank_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  bank_t                 rd_bank_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = 2 * (2 ** ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Sample storage: the bank select is the top address bit.
   // NOTE: the array has no reset on purpose; a reset would stop it mapping
   // onto RAM primitives, and every location is written before it is used.
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
      end
   end

   // Registered read, one cycle latency; the output register is cleared so
   // the fetch port reads zero straight out of reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dct_fetch_buffer.sv
// Ping-pong sample buffer in front of the DCT. Upstream fills one bank while
// the DCT fetches from the other; the DCT hands a bank back with a release
// pulse. Holds bank pointers, full flags and the valid/ready handshake.
module dct_fetch_buffer
   import jfpjc_pkg::*;
#(
   parameter int DATA_WIDTH  = SAMPLE_WIDTH,
   parameter int ADDR_WIDTH  = FETCH_ADDR_WIDTH,
   parameter int LEVEL_SHIFT = 1
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic [DATA_WIDTH-1:0] fetch_data,
   output logic                  block_valid,
   input  logic                  block_release,
   output logic                  release_err
);

   localparam logic [DATA_WIDTH-1:0] SHIFT_MASK =
      (LEVEL_SHIFT != 0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;

   bank_t                 wbank_q, wbank_d;
   bank_t                 rbank_q, rbank_d;
   logic [ADDR_WIDTH-1:0] wcount_q, wcount_d;
   logic [1:0]            bank_full_q, bank_full_d;
   logic                  release_err_q, release_err_d;

   logic                  accept;
   logic                  wr_last;
   logic                  rel_ok;

   assign in_ready    = !bank_full_q[wbank_q];
   assign block_valid = bank_full_q[rbank_q];
   assign release_err = release_err_q;

   assign accept  = in_valid && in_ready;
   assign wr_last = (wcount_q == '1);
   assign rel_ok  = block_release && block_valid;

   // Next-state for pointers and flags. A completing write and a release
   // always touch different banks (one needs empty, the other full), so
   // both updates apply independently.
   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      wbank_d       = wbank_q;
      rbank_d       = rbank_q;
      wcount_d      = wcount_q;
      bank_full_d   = bank_full_q;
      release_err_d = release_err_q;

      if (accept) begin
         wcount_d = wcount_q + 1'b1;
         if (wr_last) begin
            bank_full_d[wbank_q] = 1'b1;
            wbank_d              = other_bank(wbank_q);
         end
      end

      if (block_release) begin
         if (block_valid) begin
            bank_full_d[rbank_q] = 1'b0;
            rbank_d              = other_bank(rbank_q);
         end else begin
            release_err_d = 1'b1;
         end
      end
   end

   // Control registers; reset discards any partial or pending block.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         wbank_q       <= BANK_0;
         rbank_q       <= BANK_0;
         wcount_q      <= '0;
         bank_full_q   <= 2'b00;
         release_err_q <= 1'b0;
      end else begin
         wbank_q       <= wbank_d;
         rbank_q       <= rbank_d;
         wcount_q      <= wcount_d;
         bank_full_q   <= bank_full_d;
         release_err_q <= release_err_d;
      end
   end

   // The level shift is applied on the way in, so the stored word is already
   // the DCT's view and the cleared read register still yields zero.
   dct_fetch_bank_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clock     (clock),
      .nreset    (nreset),
      .wr_en_i   (accept),
      .wr_bank_i (wbank_q),
      .wr_addr_i (wcount_q),
      .wr_data_i (in_data ^ SHIFT_MASK),
      .rd_bank_i (rbank_q),
      .rd_addr_i (fetch_addr),
      .rd_data_o (fetch_data)
   );

   // A bank can never be completed and released in the same cycle.
   assert property (@(posedge clock) disable iff (!nreset)
      !(accept && wr_last && rel_ok && (wbank_q == rbank_q)));

endmodule
